// File: rtl/imm_gen_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pkg
// Description : Shared types for the pipelined immediate generator: the
//               format-select encoding and the skid buffer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

  localparam int SEL_W = 3;

  // Immediate format select, as driven by the main decoder
  typedef enum logic [SEL_W-1:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_BAD = 3'b111
  } imm_src_e;

  // Occupancy of the 2-entry output skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe_if
// Description : Valid/ready bundle for the immediate generator. The slave
//               modport is the generator's view, the master modport is the
//               view of the decode source / execute sink pair around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [SEL_W-1:0] imm_src;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_out;
  logic             imm_err;

  modport master (
    output in_valid, instr, imm_src, out_ready,
    input  in_ready, out_valid, imm_out, imm_err
  );

  modport slave (
    input  in_valid, instr, imm_src, out_ready,
    output in_ready, out_valid, imm_out, imm_err
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational RV32/RV64 immediate extractor. Produces the
//               XLEN-wide immediate and an illegal-select flag.
//               Optional macro IMMGEN_ERR_EN: select 111 yields 0 with the
//               error flag set; otherwise 111 decodes as an I-type.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic [31:0]      i_instr,
  input  wire logic [SEL_W-1:0] i_immSrc,
  output logic      [XLEN-1:0]  o_imm,
  output logic                  o_err
);

  // Shift amounts grow to 6 bits on RV64
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  logic [31:0] w_imm32;
  logic        w_signed;
  logic        w_extBit;
  logic        w_unusedOpcode;

  // The opcode field never contributes to an immediate
  assign w_unusedOpcode = ^i_instr[6:0];

  // Build the low 32 bits; upper bits are filled by the width stage below
  always_comb begin
    w_imm32  = '0;
    w_signed = 1'b1;
    o_err    = 1'b0;
    case (imm_src_e'(i_immSrc))
      IMM_S:  w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:  w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J:  w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
      IMM_U:  w_imm32 = {i_instr[31:12], 12'b0};
      IMM_Z: begin
        w_imm32  = {27'b0, i_instr[19:15]};
        w_signed = 1'b0;
      end
      IMM_SH: begin
        w_imm32  = 32'(i_instr[20 +: SHAMT_W]);
        w_signed = 1'b0;
      end
`ifdef IMMGEN_ERR_EN
      IMM_BAD: begin
        w_imm32  = '0;
        w_signed = 1'b0;
        o_err    = 1'b1;
      end
`endif
      default: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
    endcase
  end

  // Sign-extended formats replicate instr[31]; zero-extended ones pad with 0
  assign w_extBit = w_signed & i_instr[31];

  generate
    if (XLEN == 64) begin : g_ext64
      assign o_imm = {{32{w_extBit}}, w_imm32};
    end else begin : g_ext32
      logic w_unusedExt;
      assign w_unusedExt = w_extBit;
      assign o_imm       = w_imm32;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Pipelined immediate generator. Decodes the offered
//               instruction and holds results in a 2-entry skid buffer so
//               decode keeps full throughput under execute backpressure.
//               Optional macro IMMGEN_ERR_EN enables the illegal-select
//               error flag, which travels with its item.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic     clk,
  input  wire logic     rst,
  imm_gen_pipe_if.slave bus
);

  logic [XLEN-1:0] w_decImm;
  logic            w_decErr;
  logic            w_accept;
  logic            w_pop;

  skid_state_e     r_state;
  logic            r_outValid;
  logic            r_inReady;
  logic [XLEN-1:0] r_headImm;
  logic            r_headErr;
  logic [XLEN-1:0] r_skidImm;
  logic            r_skidErr;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .i_instr  (bus.instr),
    .i_immSrc (bus.imm_src),
    .o_imm    (w_decImm),
    .o_err    (w_decErr)
  );

  assign w_accept = bus.in_valid & r_inReady;
  assign w_pop    = r_outValid & bus.out_ready;

  // Skid buffer FSM: head feeds the output, skid catches one extra item
  // while the sink stalls; handshake outputs are registered with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
      r_headImm  <= '0;
      r_headErr  <= 1'b0;
      r_skidImm  <= '0;
      r_skidErr  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_headImm  <= w_decImm;
            r_headErr  <= w_decErr;
            r_outValid <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_pop) begin
            r_skidImm <= w_decImm;
            r_skidErr <= w_decErr;
            r_inReady <= 1'b0;
            r_state   <= ST_TWO;
          end else if (w_accept && w_pop) begin
            r_headImm <= w_decImm;
            r_headErr <= w_decErr;
          end else if (w_pop) begin
            r_outValid <= 1'b0;
            r_state    <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_headImm <= r_skidImm;
            r_headErr <= r_skidErr;
            r_inReady <= 1'b1;
            r_state   <= ST_ONE;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.imm_out   = r_headImm;
  assign bus.imm_err   = r_headErr;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench driving an XLEN=32 and an XLEN=64
//               instance with identical stimulus; directed cases followed by
//               random traffic scored against an arithmetic reference model.
//               Honours IMMGEN_ERR_EN for the illegal-select expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid;
  logic [31:0] instr;
  logic [2:0]  sel;
  logic        outReady;
  logic        lastAccepted;

  int   nChecks = 0;
  int   nErrors = 0;
  exp_t q[$];

  imm_gen_pipe_if #(.XLEN(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64)) bus64 ();

  assign bus32.in_valid  = inValid;
  assign bus32.instr     = instr;
  assign bus32.imm_src   = sel;
  assign bus32.out_ready = outReady;
  assign bus64.in_valid  = inValid;
  assign bus64.instr     = instr;
  assign bus64.imm_src   = sel;
  assign bus64.out_ready = outReady;

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  always #5 clk = ~clk;

  // Reference: immediate value as plain two's-complement arithmetic
  function automatic logic [64:0] refImm(input logic [31:0] ins, input logic [2:0] s, input int xlen);
    logic [63:0] v;
    logic        e;
    e = 1'b0;
    case (s)
      3'd1: v = 64'({ins[31:25], ins[11:7]}) - (ins[31] ? 64'd4096 : 64'd0);
      3'd2: v = 64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}) - (ins[31] ? 64'd8192 : 64'd0);
      3'd3: v = 64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}) - (ins[31] ? 64'd2097152 : 64'd0);
      3'd4: v = 64'(ins[31:12]) * 64'd4096 - (ins[31] ? 64'h1_0000_0000 : 64'd0);
      3'd5: v = 64'(ins[19:15]);
      3'd6: v = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
      3'd7: begin
`ifdef IMMGEN_ERR_EN
        v = 64'd0;
        e = 1'b1;
`else
        v = 64'(ins[31:20]) - (ins[31] ? 64'd4096 : 64'd0);
`endif
      end
      default: v = 64'(ins[31:20]) - (ins[31] ? 64'd4096 : 64'd0);
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {e, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score outputs against the model queue, then advance
  task automatic cycle();
    bit          doPop;
    bit          doPush;
    logic [64:0] r32;
    logic [64:0] r64;
    doPop  = outReady && (q.size() > 0);
    doPush = inValid && (q.size() < 2);
    chk("out_valid32", bus32.out_valid, q.size() > 0);
    chk("in_ready32",  bus32.in_ready,  q.size() < 2);
    chk("out_valid64", bus64.out_valid, q.size() > 0);
    chk("in_ready64",  bus64.in_ready,  q.size() < 2);
    if (q.size() > 0) begin
      chk("imm_out32", bus32.imm_out, q[0].e32);
      chk("imm_out64", bus64.imm_out, q[0].e64);
      chk("imm_err32", bus32.imm_err, q[0].err);
      chk("imm_err64", bus64.imm_err, q[0].err);
    end
    if (doPop) void'(q.pop_front());
    if (doPush) begin
      r32 = refImm(instr, sel, 32);
      r64 = refImm(instr, sel, 64);
      q.push_back('{e32: r32[31:0], e64: r64[63:0], err: r64[64]});
    end
    lastAccepted = doPush;
    @(posedge clk);
    #1;
  endtask

  // Single item into an empty buffer; result must appear one cycle later
  task automatic xfer1(input string tag, input logic [31:0] ins, input logic [2:0] s,
                       input logic [31:0] x32, input logic [63:0] x64, input logic xerr);
    outReady = 1'b1;
    inValid  = 1'b1;
    instr    = ins;
    sel      = s;
    cycle();
    inValid = 1'b0;
    sel     = 'x;
    chk({tag, "_valid"}, bus32.out_valid, 1);
    chk({tag, "_32"}, bus32.imm_out, x32);
    chk({tag, "_64"}, bus64.imm_out, x64);
    chk({tag, "_err32"}, bus32.imm_err, xerr);
    chk({tag, "_err64"}, bus64.imm_err, xerr);
    cycle();
  endtask

  initial begin
    inValid      = 1'b0;
    instr        = '0;
    sel          = '0;
    outReady     = 1'b0;
    lastAccepted = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_out_valid", bus32.out_valid, 0);
    chk("rst_in_ready",  bus32.in_ready,  1);
    chk("rst_imm_out32", bus32.imm_out,   0);
    chk("rst_imm_out64", bus64.imm_out,   0);
    chk("rst_imm_err",   bus64.imm_err,   0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Each format
    xfer1("I",  32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    xfer1("S",  32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    xfer1("B",  32'h00000463, 3'd2, 32'h00000008, 64'h00000000_00000008, 1'b0);
    xfer1("J",  32'h0080006F, 3'd3, 32'h00000008, 64'h00000000_00000008, 1'b0);
    xfer1("U",  32'h12345037, 3'd4, 32'h12345000, 64'h00000000_12345000, 1'b0);
    xfer1("Un", 32'h80000037, 3'd4, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
    xfer1("Z",  32'h000F8073, 3'd5, 32'h0000001F, 64'h00000000_0000001F, 1'b0);
    xfer1("SH", 32'h03F01013, 3'd6, 32'h0000001F, 64'h00000000_0000003F, 1'b0);
`ifdef IMMGEN_ERR_EN
    xfer1("BAD", 32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0, 1'b1);
`else
    xfer1("BAD", 32'hFFFFFFFF, 3'd7, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
`endif

    // Backpressure: fill both entries, stall a third offer, then drain
    outReady = 1'b0;
    inValid  = 1'b1;
    sel      = 3'd0;
    instr    = 32'h00100093;
    cycle();
    instr = 32'h00200093;
    cycle();
    chk("bp_full_in_ready", bus32.in_ready, 0);
    instr = 32'h00300093;
    cycle();
    cycle();
    chk("bp_stall_in_ready", bus32.in_ready, 0);
    chk("bp_hold_imm", bus32.imm_out, 1);
    outReady = 1'b1;
    cycle();
    chk("bp_pop1_in_ready", bus32.in_ready, 1);
    chk("bp_pop1_imm", bus32.imm_out, 2);
    cycle();
    inValid = 1'b0;
    sel     = 'x;
    chk("bp_third_imm", bus64.imm_out, 3);
    cycle();
    chk("bp_drained", bus32.out_valid, 0);

    // Asynchronous reset while full
    outReady = 1'b0;
    inValid  = 1'b1;
    sel      = 3'd0;
    instr    = 32'h00500093;
    cycle();
    instr = 32'h00600093;
    cycle();
    inValid = 1'b0;
    sel     = 'x;
    chk("pre_rst_full", bus32.in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid32", bus32.out_valid, 0);
    chk("arst_in_ready32",  bus32.in_ready,  1);
    chk("arst_out_valid64", bus64.out_valid, 0);
    chk("arst_imm_out",     bus64.imm_out,   0);
    q.delete();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic with random backpressure; offers are held until taken
    inValid      = 1'b0;
    lastAccepted = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!inValid || lastAccepted) begin
        inValid = ($urandom_range(0, 3) != 0);
        if (inValid) begin
          instr = $urandom;
          sel   = 3'($urandom_range(0, 7));
        end else begin
          sel = 'x;
        end
      end
      outReady = ($urandom_range(0, 2) != 0);
      cycle();
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
